mot_fault_monitor: RTL
======================

MOT_FAULT_MONITOR -- requirements
Module: mot_fault_monitor

Interface
REQ-001 Parameter DEB_LEN, default 8: consecutive stable cycles required to accept a level change on any debounced input.
REQ-002 Parameter FB_TIMEOUT, default 1000: maximum cycles from motor enable to accepted run feedback.
REQ-003 CLK  in  1  single system clock; all logic on rising edge.
REQ-004 RSTn  in  1  asynchronous active-low reset.
REQ-005 MOT_ENA  in  5  per-motor enable from the machine controller; synchronous to CLK.
REQ-006 MOT_FB  in  5  raw per-motor running feedback, active high, asynchronous to CLK.
REQ-007 MOT_OC  in  5  raw per-motor overcurrent flag, active high, asynchronous to CLK.
REQ-008 SENS_RAWn  in  3  raw fail sensors, active low, asynchronous to CLK.
REQ-009 ERR_CLR  in  1  synchronous error-clear request, sampled every cycle.
REQ-010 MOT_ERR  out  5  per-motor error to controller, registered, active high.
REQ-011 FAIL_SENSn  out  3  conditioned fail sensors to controller, registered, active low.

Function
REQ-012 Every raw input bit (MOT_FB, MOT_OC, SENS_RAWn) SHALL pass a 2-flop synchronizer, then a debouncer.
REQ-013 Debouncer SHALL change its output only after the synchronized input differs from it for DEB_LEN consecutive cycles; any shorter excursion resets the count and leaves the output unchanged.
REQ-014 Latency from a stable raw change to the debounced change SHALL be 2 + DEB_LEN cycles.
REQ-015 FAIL_SENSn SHALL equal the debounced SENS_RAWn bits, no further logic.
REQ-016 Each motor SHALL have an independent FSM with states OFF, SPINUP, RUN, FAULT.
REQ-017 OFF: MOT_ENA[i]=1 -> SPINUP, clear timeout counter; else stay.
REQ-018 SPINUP: counter increments each cycle; debounced OC -> FAULT; else counter reaching FB_TIMEOUT -> FAULT; else debounced FB=1 -> RUN; else MOT_ENA[i]=0 -> OFF.
REQ-019 RUN: debounced OC=1 or debounced FB=0 -> FAULT; else MOT_ENA[i]=0 -> OFF.
REQ-020 Simultaneous fault condition and MOT_ENA[i] fall in SPINUP or RUN SHALL go to FAULT (fault wins).
REQ-021 FAULT: leave to OFF only when ERR_CLR=1 and MOT_ENA[i]=0 in the same cycle; ERR_CLR with MOT_ENA[i]=1 SHALL be ignored.
REQ-022 MOT_ERR[i] SHALL be 1 exactly while FSM i is in FAULT, asserting on the edge that enters FAULT and deasserting on the edge that leaves it.
REQ-023 Timeout counter SHALL be wide enough for FB_TIMEOUT, saturate, never wrap.
REQ-024 SPINUP entered at edge N with no feedback SHALL reach FAULT at edge N+FB_TIMEOUT.
REQ-025 ERR_CLR SHALL not affect motors outside FAULT.

Reset
REQ-026 RSTn=0 SHALL asynchronously force: all FSMs OFF, counters 0, MOT_ERR=5'b00000, FAIL_SENSn=3'b111, synchronizers and debouncers for FB/OC to 0 and for SENS to 1.
REQ-027 Reset asserted mid-operation (any state, including FAULT) SHALL discard all state; after RSTn rises, behaviour SHALL be identical to power-up.

Verification (bench: 10 ns CLK, DEB_LEN=4, FB_TIMEOUT=20)
REQ-028 MOT_ENA=5'b00001, MOT_FB[0] rises 3 cycles later and stays -> MOT_ERR stays 5'b00000; FSM0 RUN 2+4 cycles after FB rise.
REQ-029 MOT_ENA=5'b00010, MOT_FB=0 -> MOT_ERR=5'b00010 exactly 20 cycles after enable edge; ERR_CLR with ENA=1 ignored; ENA=0 plus ERR_CLR -> MOT_ERR=5'b00000 next edge.
REQ-030 Motor 2 in RUN, MOT_OC[2] pulse 3 cycles -> no error; pulse 10 cycles -> MOT_ERR=5'b00100 at 2+4 cycles after rise.
REQ-031 SENS_RAWn=3'b110 held 10 cycles -> FAIL_SENSn=3'b110 6 cycles after change; 2-cycle glitch to 3'b101 -> FAIL_SENSn unchanged.
REQ-032 Motor 4 in RUN, MOT_FB[4] debounced fall in the same cycle MOT_ENA[4] falls -> MOT_ERR=5'b10000.
REQ-033 RSTn low for 3 cycles while MOT_ERR=5'b00011 -> MOT_ERR=5'b00000, FAIL_SENSn=3'b111 immediately, without waiting for CLK.

Source files
------------

// File: rtl/mot_fault_monitor.sv
// -----------------------------------------------------------------------------
// mot_fault_monitor
//
// Supervises five motors and conditions three fail sensors.
//
// Every raw asynchronous input bit (run feedback, overcurrent, fail sensor)
// passes a 2-flop synchronizer and then a debouncer. The debounced fail
// sensors go straight to the controller. The debounced feedback and
// overcurrent bits drive one independent supervision FSM per motor:
//
//   OFF    -> SPINUP  when the motor is enabled (timeout counter cleared)
//   SPINUP -> FAULT   on overcurrent or when feedback does not arrive within
//                     FB_TIMEOUT cycles
//   SPINUP -> RUN     when feedback is accepted
//   SPINUP -> OFF     when the enable drops
//   RUN    -> FAULT   on overcurrent or loss of feedback
//   RUN    -> OFF     when the enable drops
//   FAULT  -> OFF     only on an error clear while the motor is disabled
//
// A fault condition always wins over a simultaneous enable drop.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_mot_ena[4:0] per-motor enable, synchronous to i_clk
//   i_mot_fb[4:0]  raw per-motor run feedback, active high, asynchronous
//   i_mot_oc[4:0]  raw per-motor overcurrent flag, active high, asynchronous
//   i_sens_raw_n   raw fail sensors [2:0], active low, asynchronous
//   i_err_clr      error-clear request, synchronous
//   o_mot_err      per-motor error, registered, high while the motor is in FAULT
//   o_fail_sens_n  debounced fail sensors [2:0], registered, active low
// -----------------------------------------------------------------------------
module mot_fault_monitor #(
   parameter int DEB_LEN    = 8,
   parameter int FB_TIMEOUT = 1000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [4:0] i_mot_ena,
   input  logic [4:0] i_mot_fb,
   input  logic [4:0] i_mot_oc,
   input  logic [2:0] i_sens_raw_n,
   input  logic       i_err_clr,
   output logic [4:0] o_mot_err,
   output logic [2:0] o_fail_sens_n
);

   localparam int N_MOT = 5;
   localparam int N_SEN = 3;
   localparam int N_CH  = 2 * N_MOT + N_SEN;

   // Channel map: [4:0] feedback, [9:5] overcurrent, [12:10] fail sensors.
   // Feedback/overcurrent idle low, active-low sensors idle high.
   localparam logic [N_CH-1:0] CH_RST_VAL = {{N_SEN{1'b1}}, {(2 * N_MOT){1'b0}}};

   localparam int DEB_CNT_W = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
   localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_LEN - 1);

   localparam int TMO_W = $clog2(FB_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(FB_TIMEOUT);

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_SPINUP = 2'd1,
      ST_RUN    = 2'd2,
      ST_FAULT  = 2'd3
   } state_t;

   logic [N_CH-1:0]  w_raw;
   logic [2*N_MOT-1:0] w_mot_in_next;  // debounced FB/OC as they will be after this edge
   logic [N_SEN-1:0] w_sens_deb;

   assign w_raw = {i_sens_raw_n, i_mot_oc, i_mot_fb};

   // --------------------------------------------------------------------------
   // Input conditioning: synchronizer + debouncer per channel
   // --------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_cond
         logic                 r_sync1;
         logic                 r_sync2;
         logic                 r_deb;
         logic [DEB_CNT_W-1:0] r_deb_cnt;
         logic                 w_differs;
         logic                 w_deb_next;

         assign w_differs = (r_sync2 != r_deb);

         // The debounced level accepts a change on the edge that completes
         // DEB_LEN consecutive differing samples.
         assign w_deb_next = (w_differs && (r_deb_cnt == DEB_LAST)) ? r_sync2 : r_deb;

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_sync1   <= CH_RST_VAL[gi];
               r_sync2   <= CH_RST_VAL[gi];
               r_deb     <= CH_RST_VAL[gi];
               r_deb_cnt <= '0;
            end else begin
               r_sync1 <= w_raw[gi];
               r_sync2 <= r_sync1;
               if (!w_differs) begin
                  // Any excursion shorter than DEB_LEN restarts the count.
                  r_deb_cnt <= '0;
               end else if (r_deb_cnt == DEB_LAST) begin
                  r_deb_cnt <= '0;
                  r_deb     <= r_sync2;
               end else begin
                  r_deb_cnt <= r_deb_cnt + 1'b1;
               end
            end
         end

         if (gi < 2 * N_MOT) begin : g_mot_in
            // The FSMs use the debouncer's next value so that a motor reacts
            // on the same edge the debounced level changes.
            assign w_mot_in_next[gi] = w_deb_next;
         end else begin : g_sens_out
            assign w_sens_deb[gi - 2 * N_MOT] = r_deb;
         end
      end
   endgenerate

   assign o_fail_sens_n = w_sens_deb;

   // --------------------------------------------------------------------------
   // Per-motor supervision FSMs
   // --------------------------------------------------------------------------
   generate
      for (gi = 0; gi < N_MOT; gi++) begin : g_motor
         state_t           r_state;
         state_t           w_state_next;
         logic [TMO_W-1:0] r_tmo_cnt;
         logic [TMO_W-1:0] w_tmo_cnt_next;
         logic [TMO_W-1:0] w_tmo_inc;
         logic             w_tmo_hit;
         logic             r_err;
         logic             w_fb;
         logic             w_oc;
         logic             w_ena;

         assign w_fb  = w_mot_in_next[gi];
         assign w_oc  = w_mot_in_next[N_MOT + gi];
         assign w_ena = i_mot_ena[gi];

         // Saturating increment: the counter parks at FB_TIMEOUT.
         assign w_tmo_inc = (r_tmo_cnt == TMO_MAX) ? r_tmo_cnt : r_tmo_cnt + 1'b1;
         // Counter is 0 on the SPINUP entry edge, so the incremented value
         // reaches FB_TIMEOUT exactly FB_TIMEOUT edges later.
         assign w_tmo_hit = (w_tmo_inc == TMO_MAX);

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_state   <= ST_OFF;
               r_tmo_cnt <= '0;
               r_err     <= 1'b0;
            end else begin
               r_state   <= w_state_next;
               r_tmo_cnt <= w_tmo_cnt_next;
               r_err     <= (w_state_next == ST_FAULT);
            end
         end

         always_comb begin
            w_state_next   = r_state;
            w_tmo_cnt_next = r_tmo_cnt;
            case (r_state)
               ST_OFF: begin
                  if (w_ena) begin
                     w_state_next   = ST_SPINUP;
                     w_tmo_cnt_next = '0;
                  end
               end
               ST_SPINUP: begin
                  w_tmo_cnt_next = w_tmo_inc;
                  if (w_oc) begin
                     w_state_next = ST_FAULT;
                  end else if (w_tmo_hit) begin
                     w_state_next = ST_FAULT;
                  end else if (w_fb) begin
                     w_state_next = ST_RUN;
                  end else if (!w_ena) begin
                     w_state_next = ST_OFF;
                  end
               end
               ST_RUN: begin
                  if (w_oc || !w_fb) begin
                     w_state_next = ST_FAULT;
                  end else if (!w_ena) begin
                     w_state_next = ST_OFF;
                  end
               end
               ST_FAULT: begin
                  // A clear is honoured only once the controller has
                  // withdrawn the enable.
                  if (i_err_clr && !w_ena) begin
                     w_state_next = ST_OFF;
                  end
               end
               default: begin
                  w_state_next = ST_OFF;
               end
            endcase
         end

         assign o_mot_err[gi] = r_err;
      end
   endgenerate

endmodule
